// File: rtl/pcie_rx_q.sv
// ---------------------------------------------------------------------------
// pcie_rx_q
//
// Single-clock receive queue for the DMA engine's PCIe completion/request
// path. Inbound TLP words are written into a DEPTH-entry circular buffer and
// handed to one downstream consumer through a registered valid/grant output
// stage. Total capacity is DEPTH+1 words: DEPTH in the array plus one in the
// output register.
//
// Parameters:
//   WIDTH        data word width in bits
//   DEPTH        array entries (power of two, >= 4)
//   AFULL_THRESH almost_full asserts when array occupancy >= this value
//
// Ports:
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   enq_en       write strobe from the PCIe RX side
//   enq_data     word to write
//   enq_rdy      buffer can accept a word this cycle
//   almost_full  array occupancy >= AFULL_THRESH
//   rsp_v        rsp_data holds a valid word
//   rsp_data     head word, registered
//   rsp_grant    consumer takes rsp_data this cycle
//   count        words held: array occupancy plus rsp_v
//   ovf          sticky: enq_en was seen while enq_rdy was low
//   hwm          peak count (only when PCIE_RX_Q_STATS_EN is defined)
//
// Build option:
//   PCIE_RX_Q_STATS_EN  adds the hwm port and its peak-tracking register.
// ---------------------------------------------------------------------------
module pcie_rx_q #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_en,
  input  logic [WIDTH-1:0]         enq_data,
  output logic                     enq_rdy,
  output logic                     almost_full,
  output logic                     rsp_v,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_grant,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
`ifdef PCIE_RX_Q_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rsp_v_q, rsp_v_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             ovf_q, ovf_d;
  logic             rst_done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    occ_s;
  logic             empty_s;
  logic             full_s;
  logic             rdy_s;
  logic             wr_en_s;
  logic             load_s;

  // Occupancy and full/empty decode from the registered pointers only, so
  // enq_rdy never depends combinationally on rsp_grant.
  always_comb begin
    occ_s   = wr_ptr_q - rd_ptr_q;
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
              (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rdy_s   = ~full_s & rst_done_q;
    wr_en_s = enq_en & rdy_s;
    // The output stage refills when it is empty or being drained this cycle.
    load_s  = ~empty_s & (~rsp_v_q | rsp_grant);
  end

  // Next-state for pointers, output stage and overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rsp_v_d    = rsp_v_q;
    rsp_data_d = rsp_data_q;
    ovf_d      = ovf_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (load_s) begin
      rsp_data_d = mem_q[rd_ptr_q[AW-1:0]];
      rsp_v_d    = 1'b1;
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else if (rsp_grant && rsp_v_q) begin
      // Last word taken with nothing behind it; data is left as-is.
      rsp_v_d = 1'b0;
    end else begin
      rsp_v_d = rsp_v_q;
    end

    if (enq_en && !rdy_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset discards all queued contents at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      rsp_v_q    <= 1'b0;
      rsp_data_q <= {WIDTH{1'b0}};
      ovf_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
      ovf_q      <= ovf_d;
      rst_done_q <= 1'b1;
    end
  end

  // Storage array; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
    end
  end

`ifdef PCIE_RX_Q_STATS_EN
  logic [PW-1:0] hwm_q, hwm_d;

  // Peak-count tracker.
  always_comb begin
    hwm_d = hwm_q;
    if (count > hwm_q) begin
      hwm_d = count;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // Peak-count register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= {PW{1'b0}};
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

  assign enq_rdy     = rdy_s;
  assign almost_full = rst_done_q & (occ_s >= PW'(AFULL_THRESH));
  assign rsp_v       = rsp_v_q;
  assign rsp_data    = rsp_data_q;
  assign count       = occ_s + {{AW{1'b0}}, rsp_v_q};
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pcie_rx_q.sv
module tb_pcie_rx_q;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AFT   = DEPTH - 4;

  logic              clk;
  logic              rst_n;
  logic              enq_en;
  logic [WIDTH-1:0]  enq_data;
  logic              enq_rdy;
  logic              almost_full;
  logic              rsp_v;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_grant;
  logic [3:0]        count;
  logic              ovf;
`ifdef PCIE_RX_Q_STATS_EN
  logic [3:0]        hwm;
`endif

  pcie_rx_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enq_en(enq_en),
    .enq_data(enq_data),
    .enq_rdy(enq_rdy),
    .almost_full(almost_full),
    .rsp_v(rsp_v),
    .rsp_data(rsp_data),
    .rsp_grant(rsp_grant),
    .count(count),
    .ovf(ovf)
`ifdef PCIE_RX_Q_STATS_EN
    ,
    .hwm(hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the array is a plain FIFO queue of words, the output
  // stage is a valid bit plus a data word.
  logic [WIDTH-1:0] mq[$];
  logic             m_v;
  logic [WIDTH-1:0] m_data;
  logic             m_ovf;
  logic             m_rst_done;
  int               m_hwm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_v        = 1'b0;
    m_data     = '0;
    m_ovf      = 1'b0;
    m_rst_done = 1'b0;
    m_hwm      = 0;
  endtask

  // Apply one clock edge to the model using the inputs that were presented.
  task automatic model_edge(input logic en, input logic [WIDTH-1:0] d, input logic g);
    int  sz;
    bit  rdy;
    bit  ld;
    sz  = mq.size();
    rdy = (sz < DEPTH) && m_rst_done;
    ld  = (sz > 0) && (!m_v || g);
    if (sz + int'(m_v) > m_hwm) m_hwm = sz + int'(m_v);
    if (en && !rdy) m_ovf = 1'b1;
    if (ld) begin
      m_data = mq.pop_front();
      m_v    = 1'b1;
    end else if (g && m_v) begin
      m_v = 1'b0;
    end
    if (en && rdy) mq.push_back(d);
    m_rst_done = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    int occ;
    occ = mq.size();
    chk({tag, ".enq_rdy"},     32'(enq_rdy),     32'((occ < DEPTH) && m_rst_done));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(m_rst_done && (occ >= AFT)));
    chk({tag, ".rsp_v"},       32'(rsp_v),       32'(m_v));
    chk({tag, ".rsp_data"},    rsp_data,         m_data);
    chk({tag, ".count"},       32'(count),       32'(occ + int'(m_v)));
    chk({tag, ".ovf"},         32'(ovf),         32'(m_ovf));
`ifdef PCIE_RX_Q_STATS_EN
    chk({tag, ".hwm"},         32'(hwm),         32'(m_hwm));
`endif
  endtask

  // One clock cycle with the given inputs; outputs checked 1 time unit after the edge.
  task automatic step(input string tag, input logic en, input logic [WIDTH-1:0] d, input logic g);
    enq_en    = en;
    enq_data  = d;
    rsp_grant = g;
    @(posedge clk);
    model_edge(en, d, g);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    enq_en    = 1'b0;
    rsp_grant = 1'b0;
    enq_data  = '0;
    #2;
    model_reset();
    compare_all({tag, ".in_reset"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all({tag, ".released"});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((mq.size() > 0 || m_v) && n < 40) begin
      step(tag, 1'b0, '0, 1'b1);
      n++;
    end
    chk({tag, ".drained"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    enq_en    = 1'b0;
    rsp_grant = 1'b0;
    enq_data  = '0;
    model_reset();
    #12;

    // Reset release: not ready before the first edge, ready after it.
    do_reset("rst");
    chk("rst.rdy_before_edge", 32'(enq_rdy), 32'd0);
    step("rst.first_edge", 1'b0, '0, 1'b0);
    chk("rst.rdy_after_edge", 32'(enq_rdy), 32'd1);

    // First word: visible two edges after the write.
    step("w1", 1'b1, 32'hA5A5_0001, 1'b0);
    chk("w1.not_bypassed", 32'(rsp_v), 32'd0);
    step("w1.load", 1'b0, '0, 1'b0);
    chk("w1.rsp_v", 32'(rsp_v), 32'd1);
    chk("w1.rsp_data", rsp_data, 32'hA5A5_0001);
    chk("w1.count", 32'(count), 32'd1);
    step("w1.stable", 1'b0, '0, 1'b0);
    chk("w1.still_held", rsp_data, 32'hA5A5_0001);
    drain("w1.drain");

    // Fill: DEPTH+1 words with no grant, then an overflowing write.
    for (int i = 0; i < DEPTH + 1; i++) begin
      step("fill", 1'b1, 32'h100 + 32'(i), 1'b0);
      chk("fill.almost_full", 32'(almost_full), 32'(i >= AFT));
    end
    chk("fill.count", 32'(count), 32'd9);
    chk("fill.enq_rdy", 32'(enq_rdy), 32'd0);
    step("fill.ovf", 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("fill.ovf_set", 32'(ovf), 32'd1);
    chk("fill.count_held", 32'(count), 32'd9);
    drain("fill.drain");
    chk("fill.ovf_sticky", 32'(ovf), 32'd1);

    // Streaming 0..99 with enq_en and rsp_grant held high.
    do_reset("rst2");
    step("rst2.edge", 1'b0, '0, 1'b0);
    begin
      int got;
      got = 0;
      for (int i = 0; i < 100; i++) begin
        if (rsp_v) begin
          chk("stream.order", rsp_data, 32'(got));
          got++;
        end
        step("stream", 1'b1, 32'(i), 1'b1);
      end
      for (int i = 0; i < 10 && rsp_v; i++) begin
        chk("stream.order", rsp_data, 32'(got));
        got++;
        step("stream.tail", 1'b0, '0, 1'b1);
      end
      chk("stream.total", 32'(got), 32'd100);
    end
    drain("stream.drain");

    // Simultaneous write and load at count=5.
    for (int i = 0; i < 5; i++) step("sim.fill", 1'b1, 32'h200 + 32'(i), 1'b0);
    chk("sim.count5", 32'(count), 32'd5);
    chk("sim.head", rsp_data, 32'h200);
    step("sim.both", 1'b1, 32'h205, 1'b1);
    chk("sim.count_same", 32'(count), 32'd5);
    chk("sim.second_word", rsp_data, 32'h201);

    // Drain, then grants on an empty queue change nothing.
    drain("drain");
    chk("drain.rsp_v", 32'(rsp_v), 32'd0);
    step("drain.idle_grant", 1'b0, '0, 1'b1);
    step("drain.idle_grant", 1'b0, '0, 1'b1);
    chk("drain.count_zero", 32'(count), 32'd0);
    chk("drain.data_held", rsp_data, 32'h205);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45));
    end
    drain("rand.drain");

    // Reset mid-stream at count=6.
    do_reset("rst3");
    step("rst3.edge", 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step("mid.fill", 1'b1, 32'h300 + 32'(i), 1'b0);
    step("mid.idle", 1'b0, '0, 1'b0);
    chk("mid.count6", 32'(count), 32'd6);
`ifdef PCIE_RX_Q_STATS_EN
    chk("mid.hwm6", 32'(hwm), 32'd6);
`endif
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("mid.async_count", 32'(count), 32'd0);
    chk("mid.async_rsp_v", 32'(rsp_v), 32'd0);
    chk("mid.async_data", rsp_data, 32'd0);
`ifdef PCIE_RX_Q_STATS_EN
    chk("mid.async_hwm", 32'(hwm), 32'd0);
`endif
    compare_all("mid.async");
    @(negedge clk);
    rst_n = 1'b1;
    step("mid.after", 1'b0, '0, 1'b0);
    step("mid.after_w", 1'b1, 32'h400, 1'b0);
    step("mid.after_l", 1'b0, '0, 1'b0);
    chk("mid.after_data", rsp_data, 32'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
